// File: rtl/game_pkg.sv
// Shared screen encoding and widths for the game sequencer and the display stage.
package game_pkg;

    localparam int STATE_W = 4;
    localparam int TIME_W  = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } state_t;

    function automatic logic is_stage(input state_t s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the clock down to a one-cycle tick every CLK_HZ enabled cycles.
module sec_prescaler #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    // Tick decodes the registered count, so it is high on the edge that wraps.
    assign tick = en && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_fsm.sv
// Screen/stage sequencer: button and stage-outcome pulses to a screen code,
// with a per-stage countdown and a restart pulse on stage entry.
module game_fsm
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 25_000_000,
    parameter int TIME_LIMIT_S = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_enter,
    input  logic              btn_back,
    input  logic              stage_clear,
    input  logic              stage_fail,
    output logic [STATE_W-1:0] state,
    output logic [TIME_W-1:0]  time_left,
    output logic              stage_rst
);

    localparam logic [TIME_W-1:0] TIME_LIMIT = TIME_W'(TIME_LIMIT_S);

    state_t            state_q;
    logic [TIME_W-1:0] time_left_q;
    logic              stage_rst_q;
    logic              in_stage;
    logic              tick;
    logic              timeout;

    function automatic state_t success_of(input state_t s);
        case (s)
            ST_STAGE1: return ST_SUCCESS1;
            ST_STAGE2: return ST_SUCCESS2;
            default:   return ST_SUCCESS3;
        endcase
    endfunction

    assign in_stage = is_stage(state_q);
    assign timeout  = tick && (time_left_q == TIME_W'(1));

    // Counter is parked at zero whenever no stage is running.
    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (!in_stage),
        .en  (in_stage),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TITLE;
            time_left_q <= TIME_LIMIT;
            stage_rst_q <= 1'b0;
        end else begin
            stage_rst_q <= 1'b0;
            case (state_q)
                ST_TITLE: begin
                    if (btn_enter) begin
                        state_q     <= ST_STAGE1;
                        time_left_q <= TIME_LIMIT;
                        stage_rst_q <= 1'b1;
                    end else if (btn_back) begin
                        state_q <= ST_STAFF;
                    end
                end
                ST_STAFF, ST_FAIL: begin
                    if (btn_enter || btn_back) state_q <= ST_TITLE;
                end
                ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
                    // The countdown runs even on the exit edge, so a clear
                    // coinciding with timeout still shows zero seconds left.
                    if (tick && (time_left_q != '0)) time_left_q <= time_left_q - TIME_W'(1);
                    if (btn_back)                      state_q <= ST_TITLE;
                    else if (stage_clear)              state_q <= success_of(state_q);
                    else if (stage_fail || timeout)    state_q <= ST_FAIL;
                end
                ST_SUCCESS1, ST_SUCCESS2: begin
                    if (btn_enter) begin
                        state_q     <= (state_q == ST_SUCCESS1) ? ST_STAGE2 : ST_STAGE3;
                        time_left_q <= TIME_LIMIT;
                        stage_rst_q <= 1'b1;
                    end
                end
                ST_SUCCESS3: begin
                    if (btn_enter) state_q <= ST_TITLE;
                end
                default: state_q <= ST_TITLE;
            endcase
        end
    end

    assign state     = state_q;
    assign time_left = time_left_q;
    assign stage_rst = stage_rst_q;

endmodule

// File: doc/game_fsm.md
# game_fsm

Top-level screen/stage sequencer for the game. It turns debounced one-pulse button events and stage outcome pulses into the 4-bit `state` code consumed by the downstream display stage, `game_display`. It also runs the per-stage countdown timer and issues a stage-restart pulse to the stage logic. It sits directly upstream of `game_display` and shares its state encoding.

## Interface
- `CLK_HZ`, default 25_000_000: clock cycles per second, the VGA pixel clock; ≥ 2.
- `TIME_LIMIT_S`, default 60: seconds allowed per stage; range 1..127.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_enter`  in  1  one-cycle pulse, already debounced.
- `btn_back`  in  1  one-cycle pulse, already debounced.
- `stage_clear`  in  1  one-cycle pulse from stage logic: goal reached.
- `stage_fail`  in  1  one-cycle pulse from stage logic: player lost.
- `state`  out  4  current screen code: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
- `time_left`  out  7  seconds remaining in the current or last stage.
- `stage_rst`  out  1  one-cycle pulse, high during the first cycle of any STAGEn.

## Operation
- Reset values: `state`=TITLE, `time_left`=TIME_LIMIT_S, `stage_rst`=0, prescaler=0.
- Transitions, evaluated on every rising edge:
  - TITLE: enter → STAGE1; back → STAFF; enter has priority over back.
  - STAFF: enter or back → TITLE.
  - STAGEn: evaluated in priority order:
    - back → TITLE (abort).
    - stage_clear → SUCCESSn.
    - stage_fail or timeout → FAIL.
    - otherwise stay.
  - SUCCESS1: enter → STAGE2. SUCCESS2: enter → STAGE3. SUCCESS3: enter → TITLE. Back is ignored in all SUCCESS states.
  - FAIL: enter or back → TITLE.
  - Codes 9..15, which are unreachable: → TITLE on the next edge.
- Timer:
  - On any transition into STAGEn: `time_left` ← TIME_LIMIT_S and prescaler ← 0.
  - While in STAGEn: the prescaler counts 0..CLK_HZ-1 and wraps. On each wrap, `time_left` decrements.
  - Timeout occurs when the prescaler wraps while `time_left`==1. On that edge `time_left` becomes 0 and `state` becomes FAIL.
  - `time_left` never underflows.
- Outside STAGE states, the prescaler is held at 0 and `time_left` holds its value, so SUCCESS and FAIL screens show the remaining time.
- A stage_clear on the same edge as timeout wins: the result is SUCCESSn, and `time_left` still decrements to 0.
- Pulses arriving in states that do not use them are dropped, not queued.

## Timing
- All outputs are registered. An input pulse sampled at edge k changes `state` after edge k, so latency is 1 cycle.
- `stage_rst` is registered alongside `state`: it is high exactly in the first cycle `state` shows STAGEn, and low otherwise.
- Asserting `rst` mid-stage returns all outputs to their reset values after the next edge, regardless of other inputs.
- The first decrement happens exactly CLK_HZ cycles after the stage-entry edge.
- Timeout FAIL is reached TIME_LIMIT_S × CLK_HZ cycles after stage entry.

## Structure
- Package `game_pkg` holds:
  - the 4-bit state width;
  - the nine state code constants;
  - the `time_left` width of 7.
- `game_display` imports the same package, so the encoding is defined once.
- One sub-module, `sec_prescaler`:
  - parameter CLK_HZ;
  - inputs `clk`, `rst`, `clr`, `en`;
  - output `tick`, a one-cycle pulse on wrap.
- The counter width is $clog2(CLK_HZ).
- `game_fsm` holds the state register, the next-state logic, the `time_left` register and the `stage_rst` register.

## Test plan
Bench parameters: CLK_HZ=4, TIME_LIMIT_S=3.
- Reset then idle 10 cycles → `state`=0, `time_left`=3, `stage_rst`=0 throughout.
- Full path:
  - enter → `state`=2 and `stage_rst`=1 for one cycle;
  - stage_clear after 5 cycles → `state`=3, `time_left`=2 frozen;
  - enter → 4; stage_clear → 5; enter → 6; stage_clear → 7; enter → 0.
- Timeout:
  - enter from TITLE, no further inputs;
  - `time_left` reads 3, 2, 1 at 4-cycle intervals;
  - 12 cycles after entry, `state`=8 and `time_left`=0.
- Simultaneous events:
  - stage_clear and stage_fail on the same edge in STAGE2 → 5;
  - btn_back and stage_clear together in STAGE1 → 0;
  - stage_clear coincident with the timeout edge → SUCCESSn with `time_left`=0.
- TITLE/STAFF and ignored inputs:
  - back in TITLE → 1; enter → 0;
  - stage_fail in TITLE → no change;
  - back in SUCCESS1 → no change.
- Reset mid-stage:
  - `rst` held high for 1 cycle in STAGE3 with `time_left`=1 → next cycle `state`=0 and `time_left`=3;
  - no FAIL occurs afterwards.
